// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared definitions for the execute-stage ALU slice.
// Holds the icode/ifun encodings the ALU consumes, the condition-code
// bit layout and reset value, the multiplier FSM state type, and the
// condition evaluator used for CXX/JXX.
// The optional iterative multiply is enabled by defining ALU_MULQ_EN.
package alu_exec_pkg;

  localparam int ICODE_W = 4;
  localparam int IFUN_W  = 4;

  // Instruction codes seen in the E stage
  localparam logic [ICODE_W-1:0] ICODE_NOP   = 4'h1;
  localparam logic [ICODE_W-1:0] ICODE_CXX   = 4'h2;
  localparam logic [ICODE_W-1:0] ICODE_OPQ   = 4'h6;
  localparam logic [ICODE_W-1:0] ICODE_JXX   = 4'h7;
  localparam logic [ICODE_W-1:0] ICODE_PUSHQ = 4'hA;

  // ALU function codes
  localparam logic [IFUN_W-1:0] ALU_ADDQ = 4'h0;
  localparam logic [IFUN_W-1:0] ALU_SUBQ = 4'h1;
  localparam logic [IFUN_W-1:0] ALU_ANDQ = 4'h2;
  localparam logic [IFUN_W-1:0] ALU_XORQ = 4'h3;
  localparam logic [IFUN_W-1:0] ALU_MULQ = 4'h4;

  // Condition codes carried in ifun of CXX/JXX
  localparam logic [IFUN_W-1:0] C_ALWAYS = 4'h0;
  localparam logic [IFUN_W-1:0] C_LE     = 4'h1;
  localparam logic [IFUN_W-1:0] C_L      = 4'h2;
  localparam logic [IFUN_W-1:0] C_E      = 4'h3;
  localparam logic [IFUN_W-1:0] C_NE     = 4'h4;
  localparam logic [IFUN_W-1:0] C_GE     = 4'h5;
  localparam logic [IFUN_W-1:0] C_G      = 4'h6;

  // Flag positions inside the {ZF,SF,OF} register
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  // ZF set at reset so an unconditional compare-to-zero reads "equal"
  localparam logic [2:0] CC_RESET = 3'b100;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_RUN,
    MUL_DONE
  } mulState_e;

  // Resolve a branch/move condition against the registered flags.
  // Unknown condition codes never fire.
  function automatic logic evalCond(input logic [IFUN_W-1:0] ifun,
                                    input logic [2:0] cc);
    logic zf, sf, of;
    zf = cc[CC_ZF];
    sf = cc[CC_SF];
    of = cc[CC_OF];
    case (ifun)
      C_ALWAYS: return 1'b1;
      C_LE:     return (sf ^ of) | zf;
      C_L:      return sf ^ of;
      C_E:      return zf;
      C_NE:     return ~zf;
      C_GE:     return ~(sf ^ of);
      C_G:      return ~(sf ^ of) & ~zf;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier used by alu_exec when
// ALU_MULQ_EN is defined. Retires MUL_RADIX_BITS of the multiplier per
// cycle and keeps only the low DATA_WIDTH bits of the product.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   start_i        request a multiply (sampled only while idle)
//   a_i, b_i       multiplicand / multiplier, captured on start
//   busy_o         start cycle or stepping in progress
//   done_o         product_o valid this cycle (single-cycle pulse)
//   idle_o         FSM is idle
//   product_o      low DATA_WIDTH bits of a_i*b_i
module alu_mul_iter
  import alu_exec_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int MUL_RADIX_BITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  idle_o,
  output logic [DATA_WIDTH-1:0] product_o
);

  localparam int STEPS = DATA_WIDTH / MUL_RADIX_BITS;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  mulState_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] digit;
  logic [DATA_WIDTH-1:0] partial;

  // Each step multiplies the shifted multiplicand by the lowest radix
  // digit of the multiplier; the multiplicand is pre-shifted so the
  // partial product lands at the right weight without a variable shift.
  always_comb begin
    digit   = {{(DATA_WIDTH-MUL_RADIX_BITS){1'b0}}, mplier_q[MUL_RADIX_BITS-1:0]};
    partial = mcand_q * digit;
  end

  // Next-state logic: capture operands on start, step STEPS times,
  // present the product for one cycle, then return to idle.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    case (state_q)
      MUL_IDLE: begin
        if (start_i) begin
          state_d  = MUL_RUN;
          acc_d    = '0;
          mcand_d  = a_i;
          mplier_d = b_i;
          count_d  = '0;
        end
      end
      MUL_RUN: begin
        acc_d    = acc_q + partial;
        mcand_d  = mcand_q << MUL_RADIX_BITS;
        mplier_d = mplier_q >> MUL_RADIX_BITS;
        count_d  = count_q + 1'b1;
        if (count_q == CNT_W'(STEPS - 1)) begin
          state_d = MUL_DONE;
        end
      end
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any multiply in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= MUL_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
    end
  end

  // busy rises in the start cycle itself so the pipeline stalls at once
  assign busy_o    = ((state_q == MUL_IDLE) && start_i) || (state_q == MUL_RUN);
  assign done_o    = (state_q == MUL_DONE);
  assign idle_o    = (state_q == MUL_IDLE);
  assign product_o = acc_q;

endmodule

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU core. Consumes aluA/aluB/fun from operand
// select, produces valE, owns the {ZF,SF,OF} condition-code register and
// resolves e_Cnd for CXX/JXX from the registered flags.
// Optional feature macro: ALU_MULQ_EN adds an iterative MULQ (alu_mul_iter);
// without it MULQ is treated as an unsupported function and busy_o is 0.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   E_icode_i/E_ifun_i  instruction in E (ifun is the condition for CXX/JXX)
//   E_valid_i           E holds a real instruction
//   aluA_i, aluB_i      operands
//   fun_i               ALU function
//   set_cc_i            CC update permitted
//   valE_o              ALU result
//   cc_o                registered {ZF,SF,OF}
//   e_Cnd_o             condition outcome for CXX/JXX
//   busy_o              multi-cycle operation in progress
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int MUL_RADIX_BITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ICODE_W-1:0]    E_icode_i,
  input  logic [IFUN_W-1:0]     E_ifun_i,
  input  logic                  E_valid_i,
  input  logic [DATA_WIDTH-1:0] aluA_i,
  input  logic [DATA_WIDTH-1:0] aluB_i,
  input  logic [IFUN_W-1:0]     fun_i,
  input  logic                  set_cc_i,
  output logic [DATA_WIDTH-1:0] valE_o,
  output logic [2:0]            cc_o,
  output logic                  e_Cnd_o,
  output logic                  busy_o
);

  localparam int MSB = DATA_WIDTH - 1;

  logic [2:0]            cc_q, cc_d;
  logic [DATA_WIDTH-1:0] aluResult;
  logic                  aluOf;
  logic                  funSupported;
  logic                  isOpq;
  logic                  mulIdle;
  logic                  mulDone;
  logic                  mulBusy;
  logic [DATA_WIDTH-1:0] mulProduct;

  assign isOpq = E_valid_i && (E_icode_i == ICODE_OPQ);

`ifdef ALU_MULQ_EN
  logic mulStart;

  assign mulStart = isOpq && (fun_i == ALU_MULQ);

  alu_mul_iter #(
    .DATA_WIDTH    (DATA_WIDTH),
    .MUL_RADIX_BITS(MUL_RADIX_BITS)
  ) u_mul (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (mulStart),
    .a_i      (aluA_i),
    .b_i      (aluB_i),
    .busy_o   (mulBusy),
    .done_o   (mulDone),
    .idle_o   (mulIdle),
    .product_o(mulProduct)
  );
`else
  assign mulIdle    = 1'b1;
  assign mulDone    = 1'b0;
  assign mulBusy    = 1'b0;
  assign mulProduct = '0;
`endif

  // Single-cycle datapath. Overflow is signed overflow of the two's
  // complement operation; logic ops never overflow.
  always_comb begin
    aluResult    = '0;
    aluOf        = 1'b0;
    funSupported = 1'b1;
    case (fun_i)
      ALU_ADDQ: begin
        aluResult = aluA_i + aluB_i;
        aluOf     = (aluA_i[MSB] == aluB_i[MSB]) && (aluResult[MSB] != aluA_i[MSB]);
      end
      ALU_SUBQ: begin
        aluResult = aluA_i - aluB_i;
        aluOf     = (aluA_i[MSB] != aluB_i[MSB]) && (aluResult[MSB] != aluA_i[MSB]);
      end
      ALU_ANDQ: aluResult = aluA_i & aluB_i;
      ALU_XORQ: aluResult = aluA_i ^ aluB_i;
      default:  funSupported = 1'b0;
    endcase
  end

  // Next CC: a finishing multiply writes its product flags; otherwise a
  // permitted single-cycle OPQ writes its flags, but only while no
  // multiply owns the ALU.
  always_comb begin
    cc_d = cc_q;
    if (mulDone) begin
      if (set_cc_i) begin
        cc_d = {(mulProduct == '0), mulProduct[MSB], 1'b0};
      end
    end else if (mulIdle && isOpq && set_cc_i && funSupported) begin
      cc_d = {(aluResult == '0), aluResult[MSB], aluOf};
    end
  end

  // Architectural condition-code register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cc_q <= CC_RESET;
    end else begin
      cc_q <= cc_d;
    end
  end

  assign valE_o  = mulDone ? mulProduct : aluResult;
  assign cc_o    = cc_q;
  assign busy_o  = mulBusy;
  assign e_Cnd_o = E_valid_i &&
                   ((E_icode_i == ICODE_CXX) || (E_icode_i == ICODE_JXX)) &&
                   evalCond(E_ifun_i, cc_q);

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed bench for alu_exec. Expected values come from a
// small reference model of the ALU and condition logic, queued when a step
// is driven and compared when the outputs are sampled.
module tb_alu_exec;
  import alu_exec_pkg::*;

  localparam int W = 64;

  logic          clk_i;
  logic          rst_i;
  logic [3:0]    E_icode_i;
  logic [3:0]    E_ifun_i;
  logic          E_valid_i;
  logic [W-1:0]  aluA_i;
  logic [W-1:0]  aluB_i;
  logic [3:0]    fun_i;
  logic          set_cc_i;
  logic [W-1:0]  valE_o;
  logic [2:0]    cc_o;
  logic          e_Cnd_o;
  logic          busy_o;

  typedef struct {
    int          sel;
    logic [W-1:0] exp;
    string       tag;
  } expItem_t;

  expItem_t   sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [2:0] refCc;

  alu_exec #(.DATA_WIDTH(W), .MUL_RADIX_BITS(4)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .E_icode_i(E_icode_i),
    .E_ifun_i (E_ifun_i),
    .E_valid_i(E_valid_i),
    .aluA_i   (aluA_i),
    .aluB_i   (aluB_i),
    .fun_i    (fun_i),
    .set_cc_i (set_cc_i),
    .valE_o   (valE_o),
    .cc_o     (cc_o),
    .e_Cnd_o  (e_Cnd_o),
    .busy_o   (busy_o)
  );

  // 10-unit clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference ALU: result and {ZF,SF,OF}; ok=0 for unsupported functions
  function automatic void modelAlu(input logic [3:0] f, input logic [W-1:0] a,
                                   input logic [W-1:0] b, output logic [W-1:0] r,
                                   output logic [2:0] fl, output bit ok);
    logic ovf;
    ovf = 1'b0;
    ok  = 1'b1;
    case (f)
      4'h0: begin r = a + b; ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      4'h1: begin r = a - b; ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      4'h2: r = a & b;
      4'h3: r = a ^ b;
      default: begin r = '0; ok = 1'b0; end
    endcase
    fl = {(r == '0), r[W-1], ovf};
  endfunction

  // Reference condition evaluation from {ZF,SF,OF}
  function automatic logic modelCnd(input logic valid, input logic [3:0] icode,
                                    input logic [3:0] ifun, input logic [2:0] cc);
    logic lt;
    if (!valid || !(icode == 4'h2 || icode == 4'h7)) return 1'b0;
    lt = cc[1] ^ cc[0];
    if (ifun == 4'd0) return 1'b1;
    if (ifun == 4'd1) return lt | cc[2];
    if (ifun == 4'd2) return lt;
    if (ifun == 4'd3) return cc[2];
    if (ifun == 4'd4) return !cc[2];
    if (ifun == 4'd5) return !lt;
    if (ifun == 4'd6) return !lt && !cc[2];
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] observe(input int sel);
    case (sel)
      0:       return valE_o;
      1:       return {{(W-3){1'b0}}, cc_o};
      2:       return {{(W-1){1'b0}}, e_Cnd_o};
      default: return {{(W-1){1'b0}}, busy_o};
    endcase
  endfunction

  task automatic pushExp(input int sel, input logic [W-1:0] exp, input string tag);
    expItem_t e;
    e.sel = sel;
    e.exp = exp;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Sample a few units before the next rising edge and drain the queue
  task automatic checkOutput();
    expItem_t     e;
    logic [W-1:0] obs;
    #3;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      total++;
      assert (obs === e.exp) else begin
        bad++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Drive one E-stage instruction, queue what the model predicts for this
  // cycle, check it, then advance the model's CC for the next edge
  task automatic applyStimulus(input logic [3:0] icode, input logic [3:0] ifun,
                               input logic valid, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [3:0] f,
                               input logic setCc, input string tag);
    logic [W-1:0] r;
    logic [2:0]   fl;
    bit           ok;
    @(posedge clk_i);
    #1;
    E_icode_i = icode;
    E_ifun_i  = ifun;
    E_valid_i = valid;
    aluA_i    = a;
    aluB_i    = b;
    fun_i     = f;
    set_cc_i  = setCc;
    modelAlu(f, a, b, r, fl, ok);
    pushExp(0, r, {tag, "_valE"});
    pushExp(1, {{(W-3){1'b0}}, refCc}, {tag, "_cc"});
    pushExp(2, {{(W-1){1'b0}}, modelCnd(valid, icode, ifun, refCc)}, {tag, "_cnd"});
    pushExp(3, '0, {tag, "_busy"});
    checkOutput();
    if (valid && icode == 4'h6 && setCc && ok) refCc = fl;
  endtask

  initial begin
    logic [3:0] rf;
    rst_i     = 1'b1;
    E_icode_i = 4'h1;
    E_ifun_i  = 4'h0;
    E_valid_i = 1'b0;
    aluA_i    = '0;
    aluB_i    = '0;
    fun_i     = 4'h0;
    set_cc_i  = 1'b0;
    refCc     = 3'b100;

    // Reset state
    #12;
    pushExp(1, 64'h4, "reset_cc");
    pushExp(3, 64'h0, "reset_busy");
    pushExp(2, 64'h0, "reset_cnd");
    checkOutput();
    @(negedge clk_i);
    rst_i = 1'b0;

    // Conditions against the reset flags
    applyStimulus(4'h7, 4'd3, 1'b1, 0, 0, 4'h0, 1'b0, "jxx_e_reset");
    applyStimulus(4'h7, 4'd4, 1'b1, 0, 0, 4'h0, 1'b0, "jxx_ne_reset");

    // Signed overflow on ADDQ, then the following JXX sees the new flags
    applyStimulus(4'h6, 4'd0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 4'h0, 1'b1, "add_ovf");
    applyStimulus(4'h7, 4'd2, 1'b1, 0, 0, 4'h0, 1'b0, "jxx_l_after_ovf");
    applyStimulus(4'h7, 4'd1, 1'b1, 0, 0, 4'h0, 1'b0, "jxx_le_after_ovf");

    // SUBQ to zero: blocked CC update, then permitted
    applyStimulus(4'h6, 4'd0, 1'b1, 64'd5, 64'd5, 4'h1, 1'b0, "sub_nocc");
    applyStimulus(4'h6, 4'd0, 1'b1, 64'd5, 64'd5, 4'h1, 1'b1, "sub_cc");
    applyStimulus(4'h7, 4'd6, 1'b1, 0, 0, 4'h0, 1'b0, "jxx_g_zero");
    applyStimulus(4'h7, 4'd5, 1'b1, 0, 0, 4'h0, 1'b0, "jxx_ge_zero");

    // Non-OPQ uses the ALU without touching CC; bubbles never fire
    applyStimulus(4'hA, 4'd0, 1'b1, 64'h100, 64'h8, 4'h1, 1'b1, "pushq_sub");
    applyStimulus(4'h2, 4'd0, 1'b0, 0, 0, 4'h0, 1'b0, "cxx_bubble");
    applyStimulus(4'h2, 4'd0, 1'b1, 0, 0, 4'h0, 1'b0, "cxx_always");
    applyStimulus(4'h7, 4'd7, 1'b1, 0, 0, 4'h0, 1'b0, "jxx_bad_ifun");
    applyStimulus(4'h1, 4'd3, 1'b1, 0, 0, 4'h0, 1'b0, "nop_not_cond");

    // Logic ops: negative AND result, XOR to zero
    applyStimulus(4'h6, 4'd0, 1'b1, 64'hF000_0000_0000_00FF, 64'h8000_0000_0000_000F, 4'h2, 1'b1, "and_neg");
    applyStimulus(4'h7, 4'd2, 1'b1, 0, 0, 4'h0, 1'b0, "jxx_l_after_and");
    applyStimulus(4'h6, 4'd0, 1'b1, 64'h1234_5678, 64'h1234_5678, 4'h3, 1'b1, "xor_zero");
    applyStimulus(4'h6, 4'd0, 1'b1, 64'h8000_0000_0000_0000, 64'h1, 4'h1, 1'b1, "sub_ovf");
    applyStimulus(4'h7, 4'd5, 1'b1, 0, 0, 4'h0, 1'b0, "jxx_ge_after_subovf");

`ifndef ALU_MULQ_EN
    // Without the multiplier MULQ is an unsupported function
    applyStimulus(4'h6, 4'd0, 1'b1, 64'd3, 64'd7, 4'h4, 1'b1, "mulq_unsupported");
    applyStimulus(4'h7, 4'd0, 1'b1, 0, 0, 4'h0, 1'b0, "after_mulq");
`endif
    applyStimulus(4'h6, 4'd0, 1'b1, 64'd9, 64'd9, 4'h7, 1'b1, "fun7_unsupported");

    // Randomised OPQ each followed by a random condition probe
    for (int i = 0; i < 8; i++) begin
      rf = 4'($urandom_range(0, 3));
      applyStimulus(4'h6, 4'd0, 1'b1, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                    rf, 1'b1, "rand_op");
      applyStimulus(4'h7, 4'($urandom_range(0, 7)), 1'b1, 0, 0, 4'h0, 1'b0, "rand_cnd");
    end

`ifdef ALU_MULQ_EN
    // Iterative multiply: busy in the start cycle and 16 stepping cycles,
    // product and busy low on the 17th cycle after start
    applyStimulus(4'h6, 4'd0, 1'b1, 64'd0, 64'd0, 4'h1, 1'b1, "pre_mul_zero");
    @(posedge clk_i);
    #1;
    E_icode_i = 4'h6; E_valid_i = 1'b1; fun_i = 4'h4; set_cc_i = 1'b1;
    aluA_i = 64'h1_0000_0003; aluB_i = 64'd7;
    pushExp(3, 64'h1, "mul_start_busy");
    checkOutput();
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk_i);
      #1;
      aluA_i = {$urandom(), $urandom()};
      aluB_i = {$urandom(), $urandom()};
      pushExp(3, 64'h1, "mul_run_busy");
      pushExp(1, {{(W-3){1'b0}}, refCc}, "mul_run_cc");
      checkOutput();
    end
    @(posedge clk_i);
    #1;
    pushExp(3, 64'h0, "mul_done_busy");
    pushExp(0, 64'h7_0000_0015, "mul_product");
    checkOutput();
    refCc = 3'b000;
    applyStimulus(4'h7, 4'd3, 1'b1, 0, 0, 4'h0, 1'b0, "after_mul");

    // Reset in the middle of a multiply
    applyStimulus(4'h6, 4'd0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 4'h0, 1'b1, "pre_abort_add");
    @(posedge clk_i);
    #1;
    E_icode_i = 4'h6; E_valid_i = 1'b1; fun_i = 4'h4; set_cc_i = 1'b1;
    aluA_i = 64'd11; aluB_i = 64'd13;
    pushExp(3, 64'h1, "abort_start_busy");
    checkOutput();
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk_i);
      #1;
      pushExp(3, 64'h1, "abort_run_busy");
      checkOutput();
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    E_valid_i = 1'b0; E_icode_i = 4'h1; fun_i = 4'h0;
    pushExp(3, 64'h0, "abort_busy");
    pushExp(1, 64'h4, "abort_cc");
    checkOutput();
    @(negedge clk_i);
    rst_i = 1'b0;
    refCc = 3'b100;
    applyStimulus(4'h6, 4'd0, 1'b1, 64'd2, 64'd3, 4'h0, 1'b1, "post_abort_add");
    applyStimulus(4'h7, 4'd4, 1'b1, 0, 0, 4'h0, 1'b0, "post_abort_cnd");
`endif

    $display("[TB] directed sequence complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
